// File: rtl/code_lock_pkg.sv
// code_lock_pkg: shared state type and width helpers for the serial code lock.
package code_lock_pkg;
  typedef enum logic [1:0] {ENTRY, OPEN, LOCKOUT} lock_state_t;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int tries_w(input int m);
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/code_lock_fsm_lockout_timer.sv
// lockout_timer: loadable down-counter that parks at zero and flags it with done.
module lockout_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= load ? load_val : ((cnt != '0) ? cnt - W'(1) : cnt);
  end
  assign done = (cnt == '0);
endmodule

// File: rtl/code_lock_fsm.sv
// code_lock_fsm: serial LSB-first code lock with programmable code and timed lockout.
module code_lock_fsm
  import code_lock_pkg::*;
#(
  parameter int                  CODE_LEN       = 5,
  parameter logic [CODE_LEN-1:0] RESET_CODE     = 5'b01011,
  parameter int                  MAX_TRIES      = 3,
  parameter int                  LOCKOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             key_valid,
  input  logic                             key,
  input  logic                             lock,
  input  logic                             prog_en,
  input  logic [CODE_LEN-1:0]              prog_code,
  output logic                             unlocked,
  output logic                             alarm,
  output logic                             attempt_fail,
  output logic [tries_w(MAX_TRIES)-1:0]    tries_left
);
  localparam int CW  = cnt_w(CODE_LEN);
  localparam int TRW = tries_w(MAX_TRIES);
  localparam int LW  = cnt_w(LOCKOUT_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(CODE_LEN - 1);
  localparam logic [TRW-1:0] FULL = TRW'(MAX_TRIES);
  localparam logic [LW-1:0]  LOAD = LW'(LOCKOUT_CYCLES - 1);

  lock_state_t         state, state_n;
  logic [CW-1:0]       bit_cnt, bit_cnt_n;
  logic                mism, mism_n, miss, fail_n, tmr_load, tmr_done;
  logic [CODE_LEN-1:0] code, code_n;
  logic [TRW-1:0]      tries_n;

  lockout_timer #(.W(LW)) u_timer (
    .clk(clk), .rst(rst), .load(tmr_load), .load_val(LOAD), .done(tmr_done)
  );

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    mism_n    = mism;
    code_n    = code;
    tries_n   = tries_left;
    fail_n    = 1'b0;
    tmr_load  = 1'b0;
    miss      = mism | (key != code[bit_cnt]);
    case (state)
      ENTRY: if (key_valid) begin
        bit_cnt_n = (bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);
        mism_n    = (bit_cnt == LAST) ? 1'b0 : miss;
        if (bit_cnt == LAST) begin
          state_n  = miss ? ((tries_left == TRW'(1)) ? LOCKOUT : ENTRY) : OPEN;
          tries_n  = miss ? tries_left - TRW'(1) : FULL;
          fail_n   = miss;
          tmr_load = miss && (tries_left == TRW'(1));
        end
      end
      OPEN: begin
        code_n = prog_en ? prog_code : code;
        if (lock) begin
          state_n   = ENTRY;
          bit_cnt_n = '0;
          mism_n    = 1'b0;
        end
      end
      LOCKOUT: if (tmr_done) begin
        state_n = ENTRY;
        tries_n = FULL;
      end
      default: state_n = ENTRY;
    endcase
  end

  // Outputs are flopped from the next state so they change with the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ENTRY;
      bit_cnt      <= '0;
      mism         <= 1'b0;
      code         <= RESET_CODE;
      tries_left   <= FULL;
      attempt_fail <= 1'b0;
      unlocked     <= 1'b0;
      alarm        <= 1'b0;
    end else begin
      state        <= state_n;
      bit_cnt      <= bit_cnt_n;
      mism         <= mism_n;
      code         <= code_n;
      tries_left   <= tries_n;
      attempt_fail <= fail_n;
      unlocked     <= (state_n == OPEN);
      alarm        <= (state_n == LOCKOUT);
    end
  end
endmodule

// File: tb/tb_code_lock_fsm.sv
// tb_code_lock_fsm: directed stimulus checked against a whole-attempt behavioural model.
module tb_code_lock_fsm;
  localparam int CL = 5, MT = 3, LC = 16;
  logic       clk = 0, rst = 1, key_valid = 0, key = 0, lock = 0, prog_en = 0;
  logic [4:0] prog_code = '0;
  logic       unlocked, alarm, attempt_fail;
  logic [1:0] tries_left;
  int checks = 0, errors = 0, n;
  bit chk_en = 0;

  always #5 clk = ~clk;

  code_lock_fsm #(.CODE_LEN(CL), .RESET_CODE(5'b01011), .MAX_TRIES(MT), .LOCKOUT_CYCLES(LC)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key(key), .lock(lock), .prog_en(prog_en),
    .prog_code(prog_code), .unlocked(unlocked), .alarm(alarm), .attempt_fail(attempt_fail),
    .tries_left(tries_left)
  );

  // Model collects a whole attempt, then compares it as one vector.
  bit m_open = 0, m_fail = 0;
  int m_lock = 0, m_n = 0, m_tries = MT;
  logic [4:0] m_bits = '0, m_code = 5'b01011;
  always @(posedge clk) begin
    if (rst) begin
      m_open = 0; m_fail = 0; m_lock = 0; m_n = 0; m_tries = MT; m_code = 5'b01011;
    end else begin
      m_fail = 0;
      if (m_lock > 0) begin
        m_lock--;
        if (m_lock == 0) m_tries = MT;
      end else if (m_open) begin
        if (prog_en) m_code = prog_code;
        if (lock) begin m_open = 0; m_n = 0; end
      end else if (key_valid) begin
        m_bits[m_n] = key;
        m_n++;
        if (m_n == CL) begin
          m_n = 0;
          if (m_bits == m_code) begin m_open = 1; m_tries = MT; end
          else begin
            m_fail = 1;
            m_tries--;
            if (m_tries == 0) m_lock = LC;
          end
        end
      end
    end
  end

  task automatic cmp(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    cmp("unlocked", unlocked, m_open);
    cmp("alarm", alarm, m_lock > 0);
    cmp("attempt_fail", attempt_fail, m_fail);
    cmp("tries_left", tries_left, m_tries);
  end

  task automatic step(input logic kv, input logic k, input logic lk, input logic pe, input logic [4:0] pc);
    @(negedge clk);
    key_valid = kv; key = k; lock = lk; prog_en = pe; prog_code = pc;
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 5'b0);
  endtask
  task automatic enter(input logic [4:0] c, input int gap);
    for (int i = 0; i < CL; i++) begin
      step(1, c[i], 0, 0, 5'b0);
      repeat (gap) idle();
    end
    idle();
  endtask
  task automatic relock();
    step(0, 0, 1, 0, 5'b0);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk_en = 1;
    #1;
    cmp("lit_rst_unlocked", unlocked, 0);
    cmp("lit_rst_alarm", alarm, 0);
    cmp("lit_rst_tries", tries_left, 3);
    cmp("lit_rst_fail", attempt_fail, 0);
    enter(5'b01011, 0); #1;
    cmp("lit_open", unlocked, 1);
    cmp("lit_open_tries", tries_left, 3);
    relock(); #1;
    cmp("lit_relock", unlocked, 0);
    enter(5'b11111, 0); #1;
    cmp("lit_wrong_fail", attempt_fail, 1);
    cmp("lit_wrong_tries", tries_left, 2);
    cmp("lit_wrong_unlocked", unlocked, 0);
    idle(); #1;
    cmp("lit_fail_pulse", attempt_fail, 0);
    enter(5'b01011, 0); #1;
    cmp("lit_reopen_tries", tries_left, 3);
    relock();
    repeat (3) enter(5'b11111, 0);
    #1;
    cmp("lit_lockout_alarm", alarm, 1);
    cmp("lit_lockout_tries", tries_left, 0);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!alarm) break;
      n++;
      @(negedge clk);
      key_valid = 1; key = i[0]; lock = 1; prog_en = 1; prog_code = 5'b0;
    end
    key_valid = 0; lock = 0; prog_en = 0;
    cmp("lit_alarm_len", n, LC);
    enter(5'b01011, 0); #1;
    cmp("lit_post_lockout_open", unlocked, 1);
    cmp("lit_post_lockout_tries", tries_left, 3);
    step(0, 0, 0, 1, 5'b10100);
    relock();
    enter(5'b01011, 0); #1;
    cmp("lit_old_code_fails", attempt_fail, 1);
    enter(5'b10100, 0); #1;
    cmp("lit_new_code_open", unlocked, 1);
    relock();
    step(1, 1, 0, 0, 5'b0);
    step(1, 1, 0, 0, 5'b0);
    step(1, 0, 0, 0, 5'b0);
    idle(); rst = 1;
    idle(); rst = 0;
    #1;
    cmp("lit_midrst_unlocked", unlocked, 0);
    cmp("lit_midrst_tries", tries_left, 3);
    enter(5'b01011, 0); #1;
    cmp("lit_rst_code_open", unlocked, 1);
    relock();
    enter(5'b01011, 3); #1;
    cmp("lit_gap_open", unlocked, 1);
    relock();
    repeat (3) step(0, 0, 0, 1, 5'b00000);
    idle();
    enter(5'b01011, 0); #1;
    cmp("lit_prog_in_entry_ignored", unlocked, 1);
    step(0, 0, 1, 1, 5'b10100);
    idle();
    enter(5'b10100, 0); #1;
    cmp("lit_prog_and_lock", unlocked, 1);
    repeat (2) idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
